fb_pattern_writer: RTL and testbench
====================================

Name: fb_pattern_writer

Overview:
- Serial writer on the frame-buffer recirculation loop.
- Sits between the frame buffer's shift output and its shift input, one cell bit per clock.
- Passes cells through unchanged, except in two cases:
  - it substitutes a host-downloaded rectangular pattern at a programmable origin;
  - it clears a whole frame on request.
- Host bytes arrive over a valid/ready download port and are buffered in a small FIFO.

Parameters:
- H_TOTAL, 2198, cells per line; matches the row delay-line length.
- V_TOTAL, 1125, lines per frame.
- FIFO_DEPTH, 16, download byte FIFO entries; power of two, at least 4.
- CW, 12, width of coordinate counters and registers.

Ports:
- clock  in  1  system clock; one cell per cycle.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  pulse; cell_in this cycle is cell (0,0).
- cell_in  in  1  cell from the frame buffer shift output.
- cell_out  out  1  cell to the frame buffer shift input.
- origin_x  in  CW  pattern left column; sampled on start.
- origin_y  in  CW  pattern top line; sampled on start.
- pat_w  in  CW  pattern width in cells, 1..H_TOTAL; sampled on start.
- pat_h  in  CW  pattern height in lines, 1..V_TOTAL; sampled on start.
- start  in  1  pulse; arms a pattern write.
- clear  in  1  pulse; arms a whole-frame clear.
- dl_valid  in  1  download byte valid.
- dl_data  in  8  pattern bits, LSB = leftmost cell.
- dl_ready  out  1  FIFO can accept a byte.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a write or clear completes.
- underrun  out  1  sticky; FIFO was empty when a pattern bit was needed. Cleared by start.

Behaviour:
- Reset values: cell_out=0, dl_ready=0, busy=0, done=0, underrun=0. FIFO empty, counters 0, state IDLE.
- Latency is exactly 1 clock: cell_out(t+1) is derived from cell_in(t). The upstream delay line is sized so that this extra cycle is part of the loop.
- Position counters x, y:
  - frame_start forces x=0, y=0 for the current cell.
  - Otherwise x increments each cycle; at x=H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps at V_TOTAL-1.
- dl_ready = FIFO not full, and 0 in reset. A byte is accepted when dl_valid && dl_ready.
- FIFO writes are accepted in any state, so the host may prefill before start.
- A bit shifter holds the current byte and a 3-bit index. A new byte is popped when the index wraps or the shifter is empty. Pop and push in the same cycle are legal, including when the FIFO is full.
- Pattern rows are bit-packed continuously: no byte padding at row end.
- States:
  - IDLE: pass-through.
    - start → ARMED; latches origin and size, clears underrun.
    - clear → CLR_ARMED.
    - start and clear in the same cycle: clear wins, start is ignored.
  - ARMED: pass-through; waits for frame_start → WRITE.
    - The cell at frame_start is evaluated as (0,0) in WRITE.
  - WRITE: for cells inside the window, cell_out = next pattern bit; otherwise pass-through.
    - Window: origin_x ≤ x < origin_x+pat_w and origin_y ≤ y < origin_y+pat_h.
    - Window arithmetic is CW+1 bits wide. Cells beyond H_TOTAL-1 or V_TOTAL-1 are clipped, not wrapped, and their pattern bits are still consumed.
    - On the last window cell → DONE.
    - If the frame ends (x=H_TOTAL-1, y=V_TOTAL-1) without finishing the window → DONE.
    - If the FIFO is empty when a bit is needed: set underrun, pass the cell through, → DONE with no further substitution.
  - CLR_ARMED: waits for frame_start → CLEARING.
  - CLEARING: cell_out = 0 for all H_TOTAL*V_TOTAL cells from (0,0), then → DONE.
  - DONE: pulses done for one cycle, flushes leftover FIFO bytes and the shifter, → IDLE.
- start or clear while busy is ignored.
- frame_start mid-WRITE or mid-CLEARING resyncs the counters only; the state is unchanged.
- Reset mid-operation: the frame is left partially written; no recovery is attempted.

Decomposition:
- Package fb_pkg holds:
  - H_TOTAL, V_TOTAL, CW;
  - the state enum (IDLE, ARMED, WRITE, CLR_ARMED, CLEARING, DONE);
  - the coordinate typedef.
- One sub-module, fb_byte_fifo: synchronous FIFO with push, pop, full, empty, same-cycle push+pop, and an async active-low reset.

Test Plan:
- Reset and pass-through: hold reset_n=0 → cell_out=0, dl_ready=0. Release, drive a random cell_in stream → cell_out equals cell_in delayed by 1 for a full frame; busy=0.
- Glider write: prefill bytes 0x5A, 0x01 (9 bits); origin (10,20), pat_w=3, pat_h=3; pulse start, then frame_start.
  - Cells (10..12, 20..22) carry bits 0,1,0 / 1,1,0 / 1,0,1.
  - All other cells pass through.
  - done pulses one cycle after cell (12,22); the FIFO is empty afterwards.
- Clipping: origin (2196,1124), pat_w=4, pat_h=2, 1 byte 0xFF → only (2196,1124) and (2197,1124) are forced to 1. The frame end forces DONE, done pulses, and the leftover FIFO is flushed.
- Underrun: pat_w=16, pat_h=1, only 1 byte supplied → 8 cells written. At the 9th cell underrun=1 and the cell passes through; done pulses. A subsequent start clears underrun.
- Clear: cell_in all 1, pulse clear, then frame_start → 2,472,750 consecutive cell_out=0, then done. Pass-through resumes afterwards. A start+clear pulse in the same cycle → clear only.
- Backpressure and reset: push 17 bytes with dl_valid held high → dl_ready=0 after 16 bytes until a pop occurs. Assert reset_n low mid-WRITE → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and frame geometry for the frame-buffer pattern writer.
//   H_TOTAL / V_TOTAL : cells per line / lines per frame
//   CW                : coordinate width
//   FIFO_DEPTH        : download byte FIFO entries
package fb_pkg;

  localparam int unsigned H_TOTAL    = 2198;
  localparam int unsigned V_TOTAL    = 1125;
  localparam int unsigned CW         = 12;
  localparam int unsigned FIFO_DEPTH = 16;

  typedef logic [CW-1:0] coord_t;
  // One extra bit so origin + size never wraps.
  typedef logic [CW:0]   wcoord_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WRITE,
    CLR_ARMED,
    CLEARING,
    DONE
  } state_t;

  // Pattern window captured on start.
  typedef struct packed {
    coord_t ox;
    coord_t oy;
    coord_t w;
    coord_t h;
  } window_t;

endpackage

// File: rtl/fb_byte_fifo.sv
// Synchronous byte FIFO for pattern downloads.
//   push/wdata : write a byte (ignored when full unless popping the same cycle)
//   pop        : consume the head byte; rdata_c shows the head combinationally
//   flush      : discard all contents (wins over push)
//   full/empty : registered status flags
module fb_byte_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned DW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata_c,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_d;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata_c = mem[rd_ptr];

  // Occupancy after this cycle's push/pop/flush.
  always_comb begin
    cnt_d = cnt;
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

  // Pointers and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      cnt   <= cnt_d;
      full  <= (cnt_d == CNTW'(DEPTH));
      empty <= (cnt_d == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fb_pattern_writer.sv
// Serial writer on the frame-buffer recirculation loop: passes cells through
// with one clock of latency, substitutes a downloaded rectangular pattern at a
// programmable origin, or clears a whole frame.
//   clock, reset_n       : clock, async active-low reset
//   frame_start, cell_in : frame sync pulse and incoming cell bit
//   cell_out             : outgoing cell bit (cell_in delayed by one clock)
//   origin_x/y, pat_w/h  : pattern window, sampled on start
//   start, clear         : arm a pattern write / whole-frame clear
//   dl_valid/ready/data  : pattern byte download, LSB = leftmost cell
//   busy, done, underrun : status (underrun is sticky until the next start)
module fb_pattern_writer
  import fb_pkg::*;
#(
  parameter int unsigned H_CELLS = H_TOTAL,
  parameter int unsigned V_LINES = V_TOTAL
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          frame_start,
  input  logic          cell_in,
  output logic          cell_out,
  input  logic [CW-1:0] origin_x,
  input  logic [CW-1:0] origin_y,
  input  logic [CW-1:0] pat_w,
  input  logic [CW-1:0] pat_h,
  input  logic          start,
  input  logic          clear,
  input  logic          dl_valid,
  input  logic [7:0]    dl_data,
  output logic          dl_ready,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  state_t  state, state_d;
  coord_t  x_q, y_q, cx, cy, x_d, y_d;
  window_t win_q;
  coord_t  skip_q, skip_d;
  logic    line_end, frame_end;

  wcoord_t wx, wy, x_lo, x_hi, y_lo, y_hi, x_last, h_full;
  logic    in_win, last_cell, row_clip_end;

  logic [7:0] sh_byte;
  logic [2:0] sh_idx;
  logic       sh_valid;

  logic       fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       ready_en;

  logic act_write, act_clear, need_bit, avail, take, starve, bit_val;
  logic latch, out_d, underrun_d;

  fb_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wdata   (dl_data),
    .rdata_c (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ready_en holds dl_ready low until the first clock after reset.
  assign dl_ready  = ready_en && !fifo_full;
  assign fifo_push = dl_valid && dl_ready;

  // Current cell position; frame_start forces (0,0).
  always_comb begin
    cx        = frame_start ? '0 : x_q;
    cy        = frame_start ? '0 : y_q;
    line_end  = (cx == CW'(H_CELLS - 1));
    frame_end = line_end && (cy == CW'(V_LINES - 1));
    x_d       = line_end ? '0 : cx + CW'(1);
    y_d       = cy;
    if (line_end) y_d = (cy == CW'(V_LINES - 1)) ? '0 : cy + CW'(1);
  end

  // Window test in CW+1 bits; the last column is clipped to the line end.
  always_comb begin
    wx     = {1'b0, cx};
    wy     = {1'b0, cy};
    x_lo   = {1'b0, win_q.ox};
    y_lo   = {1'b0, win_q.oy};
    x_hi   = x_lo + {1'b0, win_q.w};
    y_hi   = y_lo + {1'b0, win_q.h};
    h_full = (CW+1)'(H_CELLS);
    x_last = (x_hi > h_full) ? h_full - (CW+1)'(1) : x_hi - (CW+1)'(1);
    in_win = (wx >= x_lo) && (wx < x_hi) && (wy >= y_lo) && (wy < y_hi);
    last_cell    = in_win && (wx == x_last) && (wy == y_hi - (CW+1)'(1));
    row_clip_end = in_win && line_end && (x_hi > h_full);
  end

  // Pattern bit supply: shifter first, else the FIFO head byte.
  always_comb begin
    act_write = (state == WRITE) || ((state == ARMED) && frame_start);
    act_clear = (state == CLEARING) || ((state == CLR_ARMED) && frame_start);
    need_bit  = act_write && (in_win || (skip_q != '0));
    avail     = sh_valid || !fifo_empty;
    bit_val   = sh_valid ? sh_byte[sh_idx] : fifo_rdata[0];
    take      = need_bit && avail;
    starve    = need_bit && !avail;
    fifo_pop  = take && !sh_valid;
  end

  // Bits of clipped columns are skipped on the following out-of-window cells.
  always_comb begin
    skip_d = skip_q;
    if (latch || fifo_flush) begin
      skip_d = '0;
    end else if (take && !in_win) begin
      skip_d = skip_q - CW'(1);
    end else if (take && row_clip_end && !last_cell) begin
      skip_d = CW'(x_hi - h_full);
    end
  end

  // Next state and cell output.
  always_comb begin
    state_d    = state;
    latch      = 1'b0;
    out_d      = cell_in;
    underrun_d = underrun;
    fifo_flush = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_d = CLR_ARMED;
        end else if (start) begin
          state_d    = ARMED;
          latch      = 1'b1;
          underrun_d = 1'b0;
        end
      end
      ARMED, WRITE: begin
        if (act_write) begin
          if (starve) begin
            underrun_d = 1'b1;
            state_d    = DONE;
          end else begin
            if (in_win) out_d = bit_val;
            state_d = (last_cell || frame_end) ? DONE : WRITE;
          end
        end
      end
      CLR_ARMED, CLEARING: begin
        if (act_clear) begin
          out_d   = 1'b0;
          state_d = frame_end ? DONE : CLEARING;
        end
      end
      DONE: begin
        fifo_flush = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      win_q    <= '0;
      skip_q   <= '0;
      cell_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      skip_q   <= skip_d;
      cell_out <= out_d;
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
      underrun <= underrun_d;
      ready_en <= 1'b1;
      if (latch) begin
        win_q <= '{ox: origin_x, oy: origin_y, w: pat_w, h: pat_h};
      end
    end
  end

  // Bit shifter: a byte is loaded as its first bit is used.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_byte  <= '0;
      sh_idx   <= '0;
      sh_valid <= 1'b0;
    end else if (fifo_flush) begin
      sh_valid <= 1'b0;
      sh_idx   <= '0;
    end else if (take) begin
      if (sh_valid) begin
        sh_idx <= sh_idx + 3'd1;
        if (sh_idx == 3'd7) sh_valid <= 1'b0;
      end else begin
        sh_byte  <= fifo_rdata;
        sh_idx   <= 3'd1;
        sh_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed bench for fb_pattern_writer on a reduced 40x30 frame.
module tb_fb_pattern_writer;

  localparam int H = 40;
  localparam int V = 30;
  localparam int N = H * V;
  localparam int LOGN = N + 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        frame_start, cell_in, cell_out;
  logic [11:0] origin_x, origin_y, pat_w, pat_h;
  logic        start, clear, dl_valid, dl_ready, busy, done, underrun;
  logic [7:0]  dl_data;

  int checks = 0;
  int errors = 0;

  logic cin_log  [LOGN];
  logic cout_log [LOGN];
  logic done_log [LOGN];
  logic und_log  [LOGN];
  logic busy_log [LOGN];

  fb_pattern_writer #(.H_CELLS(H), .V_LINES(V)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .cell_in     (cell_in),
    .cell_out    (cell_out),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
    .pat_w       (pat_w),
    .pat_h       (pat_h),
    .start       (start),
    .clear       (clear),
    .dl_valid    (dl_valid),
    .dl_data     (dl_data),
    .dl_ready    (dl_ready),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit ok = 1'b0;
    dl_valid = 1'b1;
    dl_data  = b;
    for (int i = 0; i < 32 && !ok; i++) begin
      ok = dl_ready;
      step();
    end
    dl_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: dl_ready never high, byte %02h", b);
    end
  endtask

  task automatic arm(input int ox, input int oy, input int w, input int h,
                     input bit do_start, input bit do_clear);
    origin_x = 12'(ox);
    origin_y = 12'(oy);
    pat_w    = 12'(w);
    pat_h    = 12'(h);
    start    = do_start;
    clear    = do_clear;
    step();
    start = 1'b0;
    clear = 1'b0;
  endtask

  // Drives n cells (frame_start on the first) and logs the outputs each cell produces.
  task automatic run_cycles(input int n, input bit ones);
    for (int i = 0; i < n; i++) begin
      frame_start = (i == 0);
      cell_in     = ones ? 1'b1 : 1'($urandom_range(0, 1));
      cin_log[i]  = cell_in;
      step();
      cout_log[i] = cell_out;
      done_log[i] = done;
      und_log[i]  = underrun;
      busy_log[i] = busy;
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    frame_start = 0; cell_in = 1; start = 0; clear = 0;
    dl_valid = 0; dl_data = 0;
    origin_x = 0; origin_y = 0; pat_w = 1; pat_h = 1;
    step(); step();
    checks++;
    if ({cell_out, dl_ready, busy, done, underrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000", {cell_out, dl_ready, busy, done, underrun});
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (dl_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", dl_ready);
    end
  endtask

  task automatic test_passthrough();
    int bad = 0, first = -1, nbusy = 0;
    run_cycles(N, 1'b0);
    for (int i = 0; i < N; i++) begin
      if (cout_log[i] !== cin_log[i]) begin
        bad++;
        if (first < 0) first = i;
      end
      if (busy_log[i] !== 1'b0 || done_log[i] !== 1'b0) nbusy++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL passthrough: %0d wrong cells, first at %0d, required 0", bad, first);
    end
    checks++;
    if (nbusy != 0) begin
      errors++;
      $display("FAIL passthrough_idle: busy/done high on %0d cells, required 0", nbusy);
    end
  endtask

  task automatic test_glider();
    logic [2:0] g_row [3];
    int bad = 0, first = -1, ndone = 0;
    g_row[0] = 3'b010;
    g_row[1] = 3'b011;
    g_row[2] = 3'b101;
    push_byte(8'h5A);
    push_byte(8'h01);
    arm(10, 20, 3, 3, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glider_busy: got %b required 1", busy);
    end
    run_cycles(N + 4, 1'b0);
    for (int i = 0; i < N + 4; i++) begin
      int x = i % H;
      int y = (i / H) % V;
      logic e = cin_log[i];
      if (i < N && x >= 10 && x <= 12 && y >= 20 && y <= 22) begin
        logic [2:0] r = g_row[y - 20];
        e = r[x - 10];
      end
      if (cout_log[i] !== e) begin
        bad++;
        if (first < 0) first = i;
      end
      if (done_log[i] === 1'b1) ndone++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glider_cells: %0d wrong cells, first at %0d, required 0", bad, first);
    end
    checks++;
    if (ndone != 1 || done_log[22*H + 12] !== 1'b1) begin
      errors++;
      $display("FAIL glider_done: %0d pulses, at cell(12,22)=%b, required 1 pulse at that cell", ndone, done_log[22*H + 12]);
    end
    checks++;
    if (busy_log[N + 3] !== 1'b0) begin
      errors++;
      $display("FAIL glider_idle: busy %b required 0", busy_log[N + 3]);
    end
  endtask

  task automatic test_clipping();
    int bad = 0, first = -1, ndone = 0;
    push_byte(8'hFF);
    push_byte(8'hA5);
    arm(H - 2, V - 1, 4, 2, 1'b1, 1'b0);
    run_cycles(N + 4, 1'b0);
    for (int i = 0; i < N + 4; i++) begin
      logic e = (i == N - 2 || i == N - 1) ? 1'b1 : cin_log[i];
      if (cout_log[i] !== e) begin
        bad++;
        if (first < 0) first = i;
      end
      if (done_log[i] === 1'b1) ndone++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clip_cells: %0d wrong cells, first at %0d, required 0", bad, first);
    end
    checks++;
    if (ndone != 1 || done_log[N - 1] !== 1'b1) begin
      errors++;
      $display("FAIL clip_done: %0d pulses, at frame end=%b, required 1 at frame end", ndone, done_log[N - 1]);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] b = 8'hC3;
    int base = 3*H + 5;
    int bad = 0, first = -1, ndone = 0;
    push_byte(b);
    arm(5, 3, 16, 1, 1'b1, 1'b0);
    run_cycles(N + 4, 1'b0);
    for (int i = 0; i < N + 4; i++) begin
      logic e = cin_log[i];
      if (i >= base && i < base + 8) e = b[i - base];
      if (cout_log[i] !== e) begin
        bad++;
        if (first < 0) first = i;
      end
      if (done_log[i] === 1'b1) ndone++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL underrun_cells: %0d wrong cells, first at %0d, required 0", bad, first);
    end
    checks++;
    if (und_log[base + 7] !== 1'b0 || und_log[base + 8] !== 1'b1 || und_log[N + 3] !== 1'b1) begin
      errors++;
      $display("FAIL underrun_flag: 8th=%b 9th=%b end=%b required 0 1 1", und_log[base + 7], und_log[base + 8], und_log[N + 3]);
    end
    checks++;
    if (ndone != 1 || done_log[base + 8] !== 1'b1) begin
      errors++;
      $display("FAIL underrun_done: %0d pulses, at 9th cell=%b, required 1 there", ndone, done_log[base + 8]);
    end
    push_byte(8'h01);
    arm(0, 0, 1, 1, 1'b1, 1'b0);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_cleared: got %b required 0", underrun);
    end
    run_cycles(8, 1'b0);
    checks++;
    if (cout_log[0] !== 1'b1 || done_log[0] !== 1'b1 || und_log[7] !== 1'b0) begin
      errors++;
      $display("FAIL single_cell: out=%b done=%b und=%b required 1 1 0", cout_log[0], done_log[0], und_log[7]);
    end
  endtask

  task automatic test_clear(input bit with_start);
    int bad = 0, first = -1, ndone = 0;
    cell_in = 1'b1;
    arm(0, 0, H, V, with_start, 1'b1);
    run_cycles(N + 4, 1'b1);
    for (int i = 0; i < N; i++) begin
      if (cout_log[i] !== 1'b0) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    for (int i = 0; i < N + 4; i++) if (done_log[i] === 1'b1) ndone++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_cells(start=%0d): %0d nonzero, first at %0d, required 0", with_start, bad, first);
    end
    checks++;
    if (ndone != 1 || done_log[N - 1] !== 1'b1 || cout_log[N] !== 1'b1 || und_log[N] !== 1'b0) begin
      errors++;
      $display("FAIL clear_end(start=%0d): pulses=%0d done@end=%b next=%b und=%b required 1 1 1 0",
               with_start, ndone, done_log[N - 1], cout_log[N], und_log[N]);
    end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    bit stuck_ok = 1'b1;
    dl_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dl_data = 8'h81 + 8'(i);
      if (dl_ready) accepted++;
      step();
    end
    dl_valid = 1'b0;
    checks++;
    if (accepted != 16 || dl_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure: accepted %0d ready %b, required 16 and 0", accepted, dl_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (dl_ready !== 1'b0) stuck_ok = 1'b0;
    end
    checks++;
    if (!stuck_ok) begin
      errors++;
      $display("FAIL ready_held_low: dl_ready rose without a pop, required 0");
    end
    arm(0, 0, 1, 1, 1'b1, 1'b0);
    frame_start = 1'b1;
    cell_in = 1'b0;
    step();
    frame_start = 1'b0;
    checks++;
    if (dl_ready !== 1'b1 || cell_out !== 1'b1) begin
      errors++;
      $display("FAIL pop_frees: ready=%b out=%b required 1 1", dl_ready, cell_out);
    end
    step(); step();
  endtask

  task automatic test_reset_mid_write();
    push_byte(8'h01);
    arm(20, 0, 1, 1, 1'b1, 1'b0);
    run_cycles(5, 1'b1);
    cell_in = 1'b1;
    checks++;
    if ({busy, cell_out, dl_ready} !== 3'b111) begin
      errors++;
      $display("FAIL mid_write_state: busy/out/ready %b required 111", {busy, cell_out, dl_ready});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cell_out, dl_ready, busy, done, underrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_write: got %b required 00000", {cell_out, dl_ready, busy, done, underrun});
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_glider();
    test_clipping();
    test_underrun();
    test_clear(1'b0);
    test_clear(1'b1);
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
